// File: rtl/dmem_wait_responder.sv
// Data-memory responder with LATENCY wait states, byte/half/word access and misalignment flag.
// Optional MMIO tohost register enabled by defining DMEM_TOHOST_EN.
module dmem_wait_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        valid,
    output logic        good,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  maskMode,
    input  logic        sext,
    output logic [31:0] readData,
    output logic        misaligned,
    output logic        test
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  mode_q, mode_d;
    logic        sext_q, sext_d;
    logic        store_q, store_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             mis;
    logic             enter_resp;
    logic             mem_we;
    logic             is_tohost;
    logic [31:0]      tohost_rd;
    logic [31:0]      word_rd;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic [3:0]       be;
    logic [31:0]      wlane;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        sext_d  = sext_q;
        store_d = store_q;
        case (state_q)
            S_IDLE: begin
                if (valid && (memRead || memWrite)) begin
                    addr_d  = addr;
                    wdata_d = writeData;
                    mode_d  = maskMode;
                    sext_d  = sext;
                    store_d = memWrite;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The access is decoded from the _d fields so that LATENCY=0, where
    // latching and RESP entry share one edge, sees the incoming request.
    always_comb begin
        idx        = addr_d[IDX_W+1:2];
        off        = addr_d[1:0];
        mis        = ((mode_d == 2'd1) && off[0]) || (mode_d[1] && (off != 2'd0));
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        mem_we     = enter_resp && store_d && !mis && !is_tohost;

        word_rd  = is_tohost ? tohost_rd : mem[idx];
        byte_sel = word_rd[{off, 3'b000} +: 8];
        half_sel = word_rd[{off[1], 4'b0000} +: 16];
        case (mode_d)
            2'd0:    load_val = sext_d ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            2'd1:    load_val = sext_d ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: load_val = word_rd;
        endcase

        case (mode_d)
            2'd0: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata_d[7:0]}};
            end
            2'd1: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_d[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_d;
            end
        endcase

        rdata_d = (enter_resp && !store_d && !mis) ? load_val : 32'h0;
        mis_d   = enter_resp && mis;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mode_q  <= 2'd0;
            sext_q  <= 1'b0;
            store_q <= 1'b0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            sext_q  <= sext_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Backing array is deliberately not reset; a held reset suppresses commits.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign good       = (state_q == S_RESP);
    assign readData   = rdata_q;
    assign misaligned = mis_q;

`ifdef DMEM_TOHOST_EN
    logic [31:0] tohost_q, tohost_d;
    logic        test_q, test_d;

    // TOHOST_ADDR is word aligned, so a match in word mode is never misaligned.
    assign is_tohost = (addr_d == TOHOST_ADDR) && mode_d[1];
    assign tohost_rd = tohost_q;

    always_comb begin
        tohost_d = tohost_q;
        if (enter_resp && store_d && is_tohost) tohost_d = wdata_d;
        test_d = (tohost_d == 32'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost_q <= 32'h0;
            test_q   <= 1'b0;
        end else begin
            tohost_q <= tohost_d;
            test_q   <= test_d;
        end
    end

    assign test = test_q;
`else
    logic unused_tohost;

    assign is_tohost     = 1'b0;
    assign tohost_rd     = 32'h0;
    assign test          = 1'b0;
    assign unused_tohost = ^{TOHOST_ADDR, addr_d[31:IDX_W+2]};
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed self-checking bench for dmem_wait_responder (LATENCY=2).
module tb_dmem_wait_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        valid;
    logic        good;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  maskMode;
    logic        sext;
    logic [31:0] readData;
    logic        misaligned;
    logic        test;

    int total = 0;
    int bad   = 0;

    dmem_wait_responder #(.DEPTH(1024), .LATENCY(LAT), .TOHOST_ADDR(32'h0000_1000)) dut (
        .clk(clk), .reset(reset), .addr(addr), .valid(valid), .good(good),
        .writeData(writeData), .memRead(memRead), .memWrite(memWrite),
        .maskMode(maskMode), .sext(sext), .readData(readData),
        .misaligned(misaligned), .test(test)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Issue one request, check response latency and the one-cycle strobe,
    // and return the sampled readData/misaligned.
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [1:0] mode, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input bit hold,
                          output logic [31:0] rdata, output logic mis);
        int lat;
        lat   = 31;
        rdata = 32'h0;
        mis   = 1'b0;
        @(negedge clk);
        valid = 1'b1; memWrite = wr; memRead = rd; maskMode = mode;
        sext = sx; addr = a; writeData = d;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (good) begin
                lat = k; rdata = readData; mis = misaligned;
                valid = 1'b0;
                break;
            end
            if (k == 1 && !hold) begin
                valid = 1'b0; addr = 32'hFFFF_FFFC; writeData = 32'h0BAD_0BAD;
                maskMode = ~mode; sext = ~sx;
            end
        end
        valid = 1'b0;
        chk({tag, " lat"}, lat, LAT + 1);
        @(negedge clk);
        chk({tag, " fall"}, {31'h0, good | misaligned | (|readData)}, 32'h0);
    endtask

    logic [31:0] rv;
    logic        mv;
    int          goods;

    initial begin
        reset = 1'b0; valid = 1'b0; addr = '0; writeData = '0;
        memRead = 1'b0; memWrite = 1'b0; maskMode = 2'd0; sext = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst good", {31'h0, good}, 32'h0);
        chk("rst rdata", readData, 32'h0);
        chk("rst mis", {31'h0, misaligned}, 32'h0);
        chk("rst test", {31'h0, test}, 32'h0);
        reset = 1'b1;

        access("st w10", 1, 0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 1, rv, mv);
        chk("st w10 rdata", rv, 32'h0);
        chk("st w10 mis", {31'h0, mv}, 32'h0);
        access("ld w10", 0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rv, mv);
        chk("ld w10 rdata", rv, 32'hDEAD_BEEF);
        chk("ld w10 mis", {31'h0, mv}, 32'h0);

        access("st b13", 1, 0, 2'd0, 0, 32'h13, 32'h0000_0080, 0, rv, mv);
        access("ld b13 s", 0, 1, 2'd0, 1, 32'h13, 32'h0, 0, rv, mv);
        chk("ld b13 s rdata", rv, 32'hFFFF_FF80);
        access("ld b13 z", 0, 1, 2'd0, 0, 32'h13, 32'h0, 0, rv, mv);
        chk("ld b13 z rdata", rv, 32'h0000_0080);
        access("ld w10b", 0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rv, mv);
        chk("ld w10b rdata", rv, 32'h80AD_BEEF);
        access("ld h12 s", 0, 1, 2'd1, 1, 32'h12, 32'h0, 0, rv, mv);
        chk("ld h12 s rdata", rv, 32'hFFFF_80AD);
        access("ld h12 z", 0, 1, 2'd1, 0, 32'h12, 32'h0, 0, rv, mv);
        chk("ld h12 z rdata", rv, 32'h0000_80AD);
        access("ld b10 s", 0, 1, 2'd0, 1, 32'h10, 32'h0, 0, rv, mv);
        chk("ld b10 s rdata", rv, 32'hFFFF_FFEF);

        access("ld h11", 0, 1, 2'd1, 0, 32'h11, 32'h0, 0, rv, mv);
        chk("ld h11 mis", {31'h0, mv}, 32'h1);
        chk("ld h11 rdata", rv, 32'h0);
        access("st h11", 1, 0, 2'd1, 0, 32'h11, 32'h0000_FFFF, 0, rv, mv);
        chk("st h11 mis", {31'h0, mv}, 32'h1);
        access("ld w12", 0, 1, 2'd2, 0, 32'h12, 32'h0, 0, rv, mv);
        chk("ld w12 mis", {31'h0, mv}, 32'h1);
        access("ld w10c", 0, 1, 2'd3, 0, 32'h10, 32'h0, 0, rv, mv);
        chk("ld w10c rdata", rv, 32'h80AD_BEEF);

        access("st w40", 1, 0, 2'd2, 0, 32'h40, 32'h1122_3344, 0, rv, mv);
        access("st h42", 1, 0, 2'd1, 0, 32'h42, 32'h0000_CAFE, 0, rv, mv);
        access("st b41", 1, 0, 2'd0, 0, 32'h41, 32'h0000_0077, 0, rv, mv);
        access("ld w40", 0, 1, 2'd2, 0, 32'h40, 32'h0, 0, rv, mv);
        chk("ld w40 rdata", rv, 32'hCAFE_7744);

        access("st w20", 1, 0, 2'd2, 0, 32'h20, 32'h0000_1234, 0, rv, mv);
        access("ld w20", 0, 1, 2'd2, 0, 32'h20, 32'h0, 0, rv, mv);
        chk("ld w20 rdata", rv, 32'h0000_1234);

        goods = 0;
        @(negedge clk);
        valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = 32'h20;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (good) goods++;
        end
        valid = 1'b0;
        chk("noop goods", goods, 0);

        access("st rw50", 1, 1, 2'd2, 0, 32'h50, 32'h0000_0099, 0, rv, mv);
        chk("st rw50 rdata", rv, 32'h0);
        access("ld w50", 0, 1, 2'd2, 0, 32'h50, 32'h0, 0, rv, mv);
        chk("ld w50 rdata", rv, 32'h0000_0099);

        access("st w30", 1, 0, 2'd2, 0, 32'h30, 32'h0000_0005, 0, rv, mv);
        @(negedge clk);
        valid = 1'b1; memWrite = 1'b1; memRead = 1'b0; maskMode = 2'd2;
        addr = 32'h30; writeData = 32'h0000_AAAA;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; memWrite = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort flags", {29'h0, good, misaligned, test}, 32'h0);
        chk("abort rdata", readData, 32'h0);
        repeat (4) @(negedge clk);
        chk("abort hold good", {31'h0, good}, 32'h0);
        reset = 1'b1;
        access("ld w30", 0, 1, 2'd2, 0, 32'h30, 32'h0, 0, rv, mv);
        chk("ld w30 rdata", rv, 32'h0000_0005);

        access("st th1", 1, 0, 2'd2, 0, 32'h1000, 32'h0000_0001, 0, rv, mv);
        @(negedge clk);
`ifdef DMEM_TOHOST_EN
        chk("tohost test1", {31'h0, test}, 32'h1);
`else
        chk("tohost test1", {31'h0, test}, 32'h0);
`endif
        access("ld th1", 0, 1, 2'd2, 0, 32'h1000, 32'h0, 0, rv, mv);
        chk("ld th1 rdata", rv, 32'h0000_0001);
        access("st th0", 1, 0, 2'd2, 0, 32'h1000, 32'h0000_0000, 0, rv, mv);
        @(negedge clk);
        chk("tohost test0", {31'h0, test}, 32'h0);
        access("ld th0", 0, 1, 2'd2, 0, 32'h1000, 32'h0, 0, rv, mv);
        chk("ld th0 rdata", rv, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
Data-memory responder for the CPU's dmem valid/good request interface. It adds a parameterised wait-state count between request and response. It performs byte, half and word accesses with optional sign extension, and flags misaligned accesses. It sits beside the CPU in Top as a drop-in, latency-injecting replacement for the single-cycle data memory, so the CPU's stall handling can be exercised.

Parameters:
DEPTH, 1024, number of 32-bit words in the backing array (power of two)
LATENCY, 2, wait cycles inserted before good (0..15)
TOHOST_ADDR, 32'h0000_1000, word-aligned address of the MMIO test register (used only with DMEM_TOHOST_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
addr  input  32  byte address
valid  input  1  request present
good  output  1  one-cycle response strobe
writeData  input  32  store data, LSB-aligned
memRead  input  1  load request
memWrite  input  1  store request
maskMode  input  2  0=byte, 1=half, 2=word, 3=word
sext  input  1  1=sign-extend byte/half loads, 0=zero-extend
readData  output  32  load result, valid while good=1
misaligned  output  1  access was misaligned, valid while good=1
test  output  1  MMIO test flag (tied 0 without DMEM_TOHOST_EN)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, good=0, readData=0, misaligned=0, test=0, counter=0. Array contents are not reset.
- Reset asserted mid-access aborts the access. A store not yet committed is dropped.
- FSM states:
  - IDLE: if valid && (memRead || memWrite): latch addr, writeData, maskMode, sext and op; load counter=LATENCY. Go to WAIT if LATENCY>0, else RESP. A request with valid=1 but neither memRead nor memWrite is ignored and no good is returned.
  - WAIT: counter decrements each cycle; move to RESP on the cycle counter==1.
  - RESP: good=1 for exactly one cycle; readData and misaligned are driven from registers; then return to IDLE.
- Latency: good is high in cycle N+LATENCY+1, where N is the cycle in which the request is sampled in IDLE.
- No request is sampled during WAIT or RESP. Peak throughput is one access per LATENCY+2 cycles.
- Request fields are latched, so valid or fields changing after acceptance do not affect the access. The access completes and good still pulses even if valid drops.
- memRead and memWrite both set: treated as a store; readData=0.
- Index = latched addr[log2(DEPTH)+1:2]. Addresses outside DEPTH wrap modulo DEPTH.
- Store commit: on the clock edge entering RESP. Only the selected bytes are written:
  - byte: lane addr[1:0]
  - half: lanes addr[1]*2 .. +1
  - word: all four lanes
- Load: read at RESP entry. Selected lane(s) are shifted to bit 0, then sign- or zero-extended per sext. For word loads sext is ignored.
- Misaligned: half with addr[0]=1, or word/mode 3 with addr[1:0]!=0. The array is not written, readData=0, and misaligned=1 together with good.
- A load following a store to the same word returns the stored data, since the store is already committed.
- readData and misaligned return to 0 when good falls.

Optional Feature:
Macro DMEM_TOHOST_EN.
- Defined: an aligned word store to TOHOST_ADDR writes a 32-bit tohost register instead of the array.
  - test = (tohost == 1), registered.
  - A word load from TOHOST_ADDR returns tohost.
  - Byte or half stores to TOHOST_ADDR write the array.
  - tohost resets to 0.
- Undefined: TOHOST_ADDR is ordinary memory; test is tied 0; no tohost register is built.

Test Plan:
- LATENCY=2: reset=0 then 1; word store addr=0x10, data=0xDEADBEEF, valid held -> good pulses exactly 3 cycles after acceptance, for one cycle; a following word load from 0x10 returns 0xDEADBEEF with misaligned=0.
- Byte store 0x80 to 0x13, then byte load 0x13: sext=1 -> 0xFFFFFF80, sext=0 -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
- Half load at 0x11 -> good with misaligned=1, readData=0; a half store at 0x11 leaves word 0x10 unchanged.
- Drop valid the cycle after a store is accepted (addr=0x20, data=0x1234) -> good still pulses on schedule; load 0x20 -> 0x00001234. valid with memRead=memWrite=0 -> no good for 20 cycles.
- reset=0 during WAIT of a store to 0x30 (prior value 0x5) -> good, readData, misaligned and test are 0 immediately; after release, load 0x30 returns 0x5.
- DMEM_TOHOST_EN defined: word store 0x1 to 0x1000 -> test=1; store 0x0 -> test=0; word load 0x1000 returns the last value stored. Without the macro: the same store -> test stays 0 and load 0x1000 returns 0x1.
